// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
// Optional starvation guard is enabled by defining REGFILE_SCHED_STARVE_EN.
package regfile_sched_pkg;

    localparam int          REG_AW   = 5;
    localparam int          DATA_W   = 32;
    localparam logic [4:0]  ZERO_REG = 5'd0;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Which writer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_MD   = 2'd2
    } src_sel_t;

endpackage

// File: rtl/regfile_sched_fifo.sv
// DEPTH-entry synchronous FIFO holding mul/div results awaiting the write port.
// No fall-through: a pushed entry becomes visible at dout the following cycle.
module regfile_sched_fifo
    import regfile_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  wr_req_t                  din,
    output wr_req_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    wr_req_t          mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (PW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler: arbitrates WB (priority) against queued mul/div results,
// registers the single register-file write, and keeps a busy scoreboard of
// outstanding mul/div destinations for RAW stall checks in decode.
// Define REGFILE_SCHED_STARVE_EN to bound how long WB may starve the MD queue.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; ready never depends on same-cycle valid, and a requester must hold
// valid and its payload stable until that edge.
module regfile_wr_sched
    import regfile_sched_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [REG_AW-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       md_reserve,
    input  logic [REG_AW-1:0]          md_reserve_addr,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [REG_AW-1:0]          md_addr,
    input  logic [DATA_W-1:0]          md_data,
    output logic                       rf_we,
    output logic [REG_AW-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    input  logic [REG_AW-1:0]          qry_addr1,
    input  logic [REG_AW-1:0]          qry_addr2,
    output logic                       qry_busy1,
    output logic                       qry_busy2,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       sb_err
);

    wr_req_t    md_req;
    wr_req_t    head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    src_sel_t   sel;
    logic [31:0] sb;
    logic [31:0] sb_next;
    logic       resv_conflict;

    assign md_req.addr = md_addr;
    assign md_req.data = md_data;

    // Ready comes only from the registered level, so a full FIFO that pops
    // still refuses a push in that same cycle.
    assign md_ready = !fifo_full;
    assign push     = md_valid && md_ready;
    assign pop      = (sel == SRC_MD);

    regfile_sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (md_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef REGFILE_SCHED_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    // Withholding wb_ready for one cycle hands the port to the FIFO head.
    assign wb_ready = (starve_cnt != SW'(STARVE_LIMIT));

    // Count consecutive cycles a non-empty queue is passed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = ^STARVE_LIMIT;
    assign wb_ready          = 1'b1;
`endif

    // One winner per cycle: accepted WB first, otherwise the FIFO head.
    always_comb begin
        sel = SRC_NONE;
        if (wb_valid && wb_ready) begin
            sel = SRC_WB;
        end else if (!fifo_empty) begin
            sel = SRC_MD;
        end
    end

    // Registered write port; writes to r0 complete the handshake but never assert rf_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            case (sel)
                SRC_WB: begin
                    rf_we    <= (wb_addr != ZERO_REG);
                    rf_waddr <= wb_addr;
                    rf_wdata <= wb_data;
                end
                SRC_MD: begin
                    rf_we    <= (head.addr != ZERO_REG);
                    rf_waddr <= head.addr;
                    rf_wdata <= head.data;
                end
                default: begin
                    rf_we    <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard next state: issue clears, reserve sets, and set wins on a tie.
    always_comb begin
        sb_next = sb;
        if (pop && (head.addr != ZERO_REG)) begin
            sb_next[head.addr] = 1'b0;
        end
        if (md_reserve && (md_reserve_addr != ZERO_REG)) begin
            sb_next[md_reserve_addr] = 1'b1;
        end
    end

    assign resv_conflict = md_reserve && (md_reserve_addr != ZERO_REG) && sb[md_reserve_addr];

    // Scoreboard register and sticky double-reservation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb     <= '0;
            sb_err <= 1'b0;
        end else begin
            sb <= sb_next;
            if (resv_conflict) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign qry_busy1 = sb[qry_addr1];
    assign qry_busy2 = sb[qry_addr2];

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: WB path, r0 handling, scoreboard,
// WB/MD collision, full-FIFO drain, mid-traffic reset and (with
// REGFILE_SCHED_STARVE_EN) the starvation guard.
module tb_regfile_wr_sched;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_reserve;
    logic [4:0]  md_reserve_addr;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  qry_addr1;
    logic [4:0]  qry_addr2;
    logic        qry_busy1;
    logic        qry_busy2;
    logic [2:0]  fifo_level;
    logic        sb_err;

    int checks;
    int errors;

    regfile_wr_sched #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .md_reserve      (md_reserve),
        .md_reserve_addr (md_reserve_addr),
        .md_valid        (md_valid),
        .md_ready        (md_ready),
        .md_addr         (md_addr),
        .md_data         (md_data),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .qry_addr1       (qry_addr1),
        .qry_addr2       (qry_addr2),
        .qry_busy1       (qry_busy1),
        .qry_busy2       (qry_busy2),
        .fifo_level      (fifo_level),
        .sb_err          (sb_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".we"},    {31'd0, rf_we}, {31'd0, we});
        check({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, a});
        check({tag, ".wdata"}, rf_wdata, d);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        md_reserve = 1'b0; md_reserve_addr = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
        qry_addr1 = '0; qry_addr2 = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        check_wr("rst", 1'b0, 5'd0, 32'd0);
        check("rst.level",    {29'd0, fifo_level}, 32'd0);
        check("rst.md_ready", {31'd0, md_ready}, 32'd1);
        check("rst.wb_ready", {31'd0, wb_ready}, 32'd1);
        check("rst.sb_err",   {31'd0, sb_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- WB path ----------------
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        check("wb.ready", {31'd0, wb_ready}, 32'd1);
        tick();
        check_wr("wb5", 1'b1, 5'd5, 32'hDEADBEEF);
        wb_valid = 1'b0;
        tick();
        check_wr("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h11111111;
        tick();
        check("wb0.we", {31'd0, rf_we}, 32'd0);
        wb_valid = 1'b0;
        tick();

        // ---------------- scoreboard ----------------
        md_reserve = 1'b1; md_reserve_addr = 5'd0; qry_addr2 = 5'd0;
        tick(); tick();
        md_reserve = 1'b0;
        check("r0_resv.busy2", {31'd0, qry_busy2}, 32'd0);
        check("r0_resv.sb_err", {31'd0, sb_err}, 32'd0);

        md_reserve = 1'b1; md_reserve_addr = 5'd9; qry_addr1 = 5'd9;
        check("resv9.pre_busy", {31'd0, qry_busy1}, 32'd0);
        tick();
        md_reserve = 1'b0;
        check("resv9.busy", {31'd0, qry_busy1}, 32'd1);
        check("resv9.sb_err", {31'd0, sb_err}, 32'd0);

        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h12345678;
        tick();
        md_valid = 1'b0;
        check("md9.push_level", {29'd0, fifo_level}, 32'd1);
        check("md9.no_fallthru", {31'd0, rf_we}, 32'd0);
        check("md9.busy_held", {31'd0, qry_busy1}, 32'd1);
        tick();
        check_wr("md9", 1'b1, 5'd9, 32'h12345678);
        check("md9.level", {29'd0, fifo_level}, 32'd0);
        check("md9.busy_clr", {31'd0, qry_busy1}, 32'd0);

        md_reserve = 1'b1; md_reserve_addr = 5'd9;
        tick();
        check("dbl.first_err", {31'd0, sb_err}, 32'd0);
        tick();
        md_reserve = 1'b0;
        check("dbl.sb_err", {31'd0, sb_err}, 32'd1);
        check("dbl.busy", {31'd0, qry_busy1}, 32'd1);

        // ---------------- collision ----------------
        md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h44444444;
        tick();
        md_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33333333;
        tick();
        check_wr("coll.wb3", 1'b1, 5'd3, 32'h33333333);
        check("coll.level", {29'd0, fifo_level}, 32'd1);
        wb_valid = 1'b0;
        tick();
        check_wr("coll.md4", 1'b1, 5'd4, 32'h44444444);
        check("coll.level0", {29'd0, fifo_level}, 32'd0);

        // ---------------- full FIFO ----------------
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77777777;
        for (int i = 0; i < 4; i++) begin
            md_valid = 1'b1; md_addr = 5'(10 + i); md_data = 32'hA0 + 32'(i);
            tick();
            check_wr("full.wb7", 1'b1, 5'd7, 32'h77777777);
        end
        check("full.level", {29'd0, fifo_level}, 32'd4);
        check("full.md_ready", {31'd0, md_ready}, 32'd0);
        md_addr = 5'd20; md_data = 32'h55;
        tick();
        check("full.held_level", {29'd0, fifo_level}, 32'd4);
        check("full.held_ready", {31'd0, md_ready}, 32'd0);
        wb_valid = 1'b0;
        tick();
        check_wr("drain0", 1'b1, 5'd10, 32'hA0);
        check("drain0.level", {29'd0, fifo_level}, 32'd3);
        check("drain0.md_ready", {31'd0, md_ready}, 32'd1);
        tick();
        md_valid = 1'b0;
        check_wr("drain1", 1'b1, 5'd11, 32'hA1);
        check("drain1.level", {29'd0, fifo_level}, 32'd3);
        tick();
        check_wr("drain2", 1'b1, 5'd12, 32'hA2);
        tick();
        check_wr("drain3", 1'b1, 5'd13, 32'hA3);
        tick();
        check_wr("drain4", 1'b1, 5'd20, 32'h55);
        check("drain4.level", {29'd0, fifo_level}, 32'd0);
        tick();
        check("drain.idle", {31'd0, rf_we}, 32'd0);

        // ---------------- mid-traffic reset ----------------
        md_reserve = 1'b1; md_reserve_addr = 5'd12; qry_addr1 = 5'd12; qry_addr2 = 5'd9;
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h22222222;
        md_valid = 1'b1; md_addr = 5'd12; md_data = 32'hC12;
        tick();
        md_reserve = 1'b0;
        md_addr = 5'd13; md_data = 32'hC13;
        tick();
        md_valid = 1'b0;
        check("pre_rst.level", {29'd0, fifo_level}, 32'd2);
        check("pre_rst.busy1", {31'd0, qry_busy1}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst.we", {31'd0, rf_we}, 32'd0);
        check("mrst.level", {29'd0, fifo_level}, 32'd0);
        check("mrst.busy1", {31'd0, qry_busy1}, 32'd0);
        check("mrst.busy2", {31'd0, qry_busy2}, 32'd0);
        check("mrst.md_ready", {31'd0, md_ready}, 32'd1);
        check("mrst.sb_err", {31'd0, sb_err}, 32'd0);
        wb_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst.we", {31'd0, rf_we}, 32'd0);
        tick();
        check("post_rst.we2", {31'd0, rf_we}, 32'd0);
        check("post_rst.level", {29'd0, fifo_level}, 32'd0);

`ifdef REGFILE_SCHED_STARVE_EN
        // ---------------- starvation guard ----------------
        wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h66666666;
        md_valid = 1'b1; md_addr = 5'd8; md_data = 32'h88888888;
        tick();
        md_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("starve.ready_hi", {31'd0, wb_ready}, 32'd1);
            tick();
            check_wr("starve.wb6", 1'b1, 5'd6, 32'h66666666);
        end
        check("starve.ready_lo", {31'd0, wb_ready}, 32'd0);
        tick();
        check_wr("starve.md8", 1'b1, 5'd8, 32'h88888888);
        check("starve.ready_back", {31'd0, wb_ready}, 32'd1);
        tick();
        check_wr("starve.retry6", 1'b1, 5'd6, 32'h66666666);
        wb_valid = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
